// File: rtl/osc_meter_pkg.sv
// Shared types and constants for the oscillator frequency meter.
// Optional build macro: OSC_METER_GLITCH_FILTER_EN (adds a 3-sample majority
// filter after the synchronizer, two extra cycles of edge latency).
package osc_meter_pkg;

    // Measurement controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } meter_state_t;

    // Flops in the osc_in synchronizer chain
    localparam int SYNC_STAGES = 2;

`ifdef OSC_METER_GLITCH_FILTER_EN
    // Majority history plus the registered vote
    localparam int FILTER_LATENCY = 2;
`else
    localparam int FILTER_LATENCY = 0;
`endif

    // osc_in rising edge to edge_p pulse, in clk cycles
    localparam int EDGE_LATENCY = SYNC_STAGES + FILTER_LATENCY + 1;

endpackage

// File: rtl/osc_meter_sync.sv
// Brings the asynchronous oscillator signal into the clk domain and emits a
// one-cycle pulse per rising edge.
// Optional build macro: OSC_METER_GLITCH_FILTER_EN (majority filter stage).
module osc_meter_sync
    import osc_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level;
    logic                   level_prev_q;
    logic                   level_prev_d;
    logic                   edge_q;
    logic                   edge_d;

    // Synchronizer chain: stage 0 samples osc_in, later stages shift it along
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = osc_in;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
            // One synchronizer flop
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q[gi] <= 1'b0;
                else     sync_q[gi] <= sync_d[gi];
            end
        end
    endgenerate

`ifdef OSC_METER_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic [1:0] hist_d;
    logic       filt_q;
    logic       filt_d;

    // Majority of the current and two previous synchronized samples, so a
    // single-cycle excursion never wins the vote
    always_comb begin
        hist_d = {hist_q[0], sync_q[SYNC_STAGES-1]};
        filt_d = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                 (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);
    end

    // Filter history and vote registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    // Rising-edge detect on the clean level
    always_comb begin
        level_prev_d = level;
        edge_d       = level & ~level_prev_q;
    end

    // Detector registers; edge_p comes straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_q <= 1'b0;
            edge_q       <= 1'b0;
        end else begin
            level_prev_q <= level_prev_d;
            edge_q       <= edge_d;
        end
    end

    assign edge_p = edge_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts oscillator rising edges over a fixed window of GATE_CYCLES clk
// cycles and hands each count out over a valid/ready interface.
// Optional build macro: OSC_METER_GLITCH_FILTER_EN (see osc_meter_sync).
module osc_freq_meter
    import osc_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 65536,
    parameter int unsigned CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    localparam logic [31:0] GATE_LOAD = 32'(GATE_CYCLES - 1);

    meter_state_t     state_q, state_d;
    logic [31:0]      gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_ovf_q, run_ovf_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;
    logic             arm;
    logic             edge_p;

    osc_meter_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .edge_p (edge_p)
    );

    // Next-state logic: gate timing, saturating edge count, result capture
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        run_ovf_d  = run_ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        arm        = 1'b0;

        // Count including this cycle's edge; stick at all-ones rather than wrap
        cnt_inc = cnt_q;
        ovf_inc = run_ovf_q;
        if (edge_p) begin
            if (&cnt_q) ovf_inc = 1'b1;
            else        cnt_inc = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                arm = start;
            end
            COUNT: begin
                cnt_d     = cnt_inc;
                run_ovf_d = ovf_inc;
                if (gate_q == 32'd0) begin
                    // Last gate cycle: its edge is already folded into cnt_inc
                    result_d   = cnt_inc;
                    overflow_d = ovf_inc;
                    state_d    = HOLD;
                end else begin
                    gate_d = gate_q - 32'd1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    if (continuous) arm = 1'b1;
                    else            state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Arming clears only the running count; the published result and
        // overflow stay put until the next window completes
        if (arm) begin
            cnt_d     = '0;
            run_ovf_d = 1'b0;
            gate_d    = GATE_LOAD;
            state_d   = COUNT;
        end
    end

    // State, counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= 32'd0;
            cnt_q      <= '0;
            run_ovf_q  <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            run_ovf_q  <= run_ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy         = (state_q == COUNT) || (state_q == HOLD);
    assign result_valid = (state_q == HOLD);
    assign result       = result_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Randomized bench for osc_freq_meter. The reference model keeps the full
// per-cycle history of osc_in and counts edges of the delayed waveform over
// each window with plain arithmetic.
module tb_osc_freq_meter;

    localparam int G   = 100;
    localparam int W   = 4;
    localparam int MAXC = 20000;

    logic         clk;
    logic         rst;
    logic         osc_in;
    logic         start;
    logic         continuous;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         overflow;

    int n_checks;
    int n_errors;
    int cyc;
    bit osc_hist [0:MAXC-1];

    // Oscillator generator state: 0 = held low, 1 = square wave, 2 = 1-cycle pulses
    int mode;
    int per;
    int hi;
    int ph;
    bit jitter;

    osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .osc_in       (osc_in),
        .start        (start),
        .continuous   (continuous),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clk; outputs are sampled and osc_in driven 1 time unit after the edge
    task automatic step();
        bit v;
        @(posedge clk);
        #1;
        cyc++;
        v = 1'b0;
        case (mode)
            1: begin
                v = (ph < hi);
                ph++;
                if (ph >= per) begin
                    ph = 0;
                    if (jitter) hi = $urandom_range(2, per - 2);
                end
            end
            2: begin
                v = (ph == 0);
                ph++;
                if (ph >= per) ph = 0;
            end
            default: v = 1'b0;
        endcase
        osc_in = v;
        if (cyc < MAXC) osc_hist[cyc] = v;
    endtask

    task automatic set_osc(input int m, input int p, input int h, input bit j);
        mode   = m;
        per    = p;
        hi     = h;
        jitter = j;
        ph     = (p > 0) ? $urandom_range(0, p - 1) : 0;
    endtask

    function automatic bit maj3(input int j);
        return (int'(osc_hist[j]) + int'(osc_hist[j-1]) + int'(osc_hist[j-2])) >= 2;
    endfunction

    // Does a rising edge of osc_in reach the counter during cycle c?
    function automatic bit edge_at(input int c);
`ifdef OSC_METER_GLITCH_FILTER_EN
        return maj3(c - 4) && !maj3(c - 5);
`else
        return osc_hist[c-3] && !osc_hist[c-4];
`endif
    endfunction

    // Raw edge total for a window whose first counting cycle is s
    function automatic int raw_edges(input int s);
        int n;
        n = 0;
        for (int c = s; c < s + G; c++) n += int'(edge_at(c));
        return n;
    endfunction

    function automatic int sat_count(input int n);
        return (n > (1 << W) - 1) ? (1 << W) - 1 : n;
    endfunction

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (result_valid) begin
                at = cyc;
                return;
            end
            step();
        end
        if (result_valid) at = cyc;
        else chk("valid_timeout", 32'd0, 32'd1);
    endtask

    // One start, ready tied high, continuous low
    task automatic run_single(input string tag);
        int n0, at, raw;
        n0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        wait_valid(G + 10, at);
        raw = raw_edges(n0 + 1);
        chk({tag, "_valid_cycle"}, at, n0 + G + 1);
        chk({tag, "_result"}, result, sat_count(raw));
        chk({tag, "_overflow"}, overflow, raw > (1 << W) - 1);
        $display("window %s: start=%0d edges=%0d result=%0d ovf=%0d", tag, n0, raw, result, overflow);
        step();
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_valid_off"}, result_valid, 0);
    endtask

    initial begin
        int n0, at, raw, sum_exp, sum_got, p;
        logic [W-1:0] held;

        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst = 1'b1;
        osc_in = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        result_ready = 1'b1;
        set_osc(0, 0, 0, 0);

        repeat (4) step();
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (8) step();

        // Single windows: held low, nominal period 10, fast (saturating), random
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: set_osc(0, 0, 0, 0);
                1: set_osc(1, 10, 5, 0);
                2: set_osc(1, 4, 2, 0);
                default: begin
                    p = $urandom_range(6, 14);
                    set_osc(1, p, $urandom_range(2, p - 2), $urandom_range(0, 1));
                end
            endcase
            repeat ($urandom_range(0, 10)) step();
            run_single($sformatf("single%0d", i));
        end

        // Back-to-back windows in continuous mode
        set_osc(1, 10, 5, 1);
        continuous = 1'b1;
        result_ready = 1'b1;
        sum_exp = 0;
        sum_got = 0;
        n0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            wait_valid(G + 10, at);
            raw = raw_edges(n0 + 1 + w * (G + 1));
            chk($sformatf("cont%0d_cycle", w), at, n0 + 1 + w * (G + 1) + G);
            chk($sformatf("cont%0d_result", w), result, sat_count(raw));
            sum_exp += sat_count(raw);
            sum_got += int'(result);
            $display("window cont%0d: edges=%0d result=%0d", w, raw, result);
            if (w == 3) continuous = 1'b0;
            step();
            chk($sformatf("cont%0d_busy", w), busy, (w < 3) ? 1 : 0);
        end
        chk("cont_sum", sum_got, sum_exp);

        // Back-pressure: result held while ready is low; start is ignored
        repeat (5) step();
        set_osc(1, 12, 6, 0);
        result_ready = 1'b0;
        n0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(G + 10, at);
        raw = raw_edges(n0 + 1);
        chk("bp_result", result, sat_count(raw));
        held = result;
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
            chk("bp_hold_result", result, held);
            chk("bp_hold_valid", result_valid, 1);
        end
        start = 1'b0;
        $display("window bp: edges=%0d result=%0d held 20 cycles", raw, held);
        result_ready = 1'b1;
        step();
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", result_valid, 0);

        // Reset in the middle of a window
        set_osc(1, 4, 2, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        #2;
        rst = 1'b1;
        osc_in = 1'b0;
        osc_hist[cyc] = 1'b0;
        set_osc(0, 0, 0, 0);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_overflow", overflow, 0);
        $display("reset asserted mid-window at cycle %0d", cyc);
        repeat (3) step();
        rst = 1'b0;
        repeat (8) step();
        set_osc(1, 9, 4, 0);
        run_single("after_rst");

        // Single-cycle pulses: rejected only when the majority filter is built
        set_osc(2, 6, 0, 0);
        repeat (6) step();
        n0 = cyc;
        run_single("glitch");
`ifdef OSC_METER_GLITCH_FILTER_EN
        chk("glitch_zero", raw_edges(n0 + 1), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
